// File: rtl/peripheral_mpram_nr1w.sv
// peripheral_mpram_nr1w: N-read/1-write byte-maskable RAM, one array copy per read port
module peripheral_mpram_nr1w #(
  parameter int ABITS   = 10,
  parameter int DBITS   = 32,
  parameter int NRPORTS = 2,
  parameter int RDPIPE  = 0,
  parameter int BYPASS  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [ABITS-1:0]           waddr_i,
  input  logic [DBITS-1:0]           din_i,
  input  logic                       we_i,
  input  logic [(DBITS+7)/8-1:0]     be_i,
  input  logic [NRPORTS*ABITS-1:0]   raddr_i,
  input  logic [NRPORTS-1:0]         re_i,
  output logic [NRPORTS*DBITS-1:0]   dout_o,
  output logic [NRPORTS-1:0]         dvalid_o
);
  logic [DBITS-1:0] wmask;
  for (genvar i = 0; i < DBITS; i++) begin : g_mask
    assign wmask[i] = be_i[i/8];
  end
  for (genvar p = 0; p < NRPORTS; p++) begin : g_port
    logic [DBITS-1:0] mem [2**ABITS];
    logic [DBITS-1:0] rd_q, bd_q, bm_q, pd_q, rdata;
    logic             v_q, pv_q;
    logic [ABITS-1:0] ra;
    assign ra    = raddr_i[p*ABITS +: ABITS];
    assign rdata = (rd_q & ~bm_q) | (bd_q & bm_q);
    always_ff @(posedge clk_i) begin
      if (rst_ni && we_i)
        for (int i = 0; i < DBITS; i++)
          if (wmask[i]) mem[waddr_i][i] <= din_i[i];
    end
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rd_q <= '0;
        bm_q <= '0;
        v_q  <= 1'b0;
      end else begin
        v_q <= re_i[p];
        if (re_i[p]) begin
          rd_q <= mem[ra];
          bm_q <= (BYPASS != 0 && we_i && ra == waddr_i) ? wmask : '0;
          bd_q <= din_i;
        end
      end
    end
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        pd_q <= '0;
        pv_q <= 1'b0;
      end else begin
        pv_q <= v_q;
        if (v_q) pd_q <= rdata;
      end
    end
    assign dout_o[p*DBITS +: DBITS] = RDPIPE != 0 ? pd_q : rdata;
    assign dvalid_o[p]              = RDPIPE != 0 ? pv_q : v_q;
  end
endmodule

// File: tb/tb_peripheral_mpram_nr1w.sv
// tb_peripheral_mpram_nr1w: scoreboard bench for a write-first/no-pipe and a read-first/piped instance
module tb_peripheral_mpram_nr1w;
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic [9:0]  waddr = '0;
  logic [31:0] din = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [19:0] raddr = '0;
  logic [1:0]  re = '0;
  logic [63:0] dout0, dout1;
  logic [1:0]  dv0, dv1;
  logic [31:0] mdl [int];
  exp_t        sb [4][$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  peripheral_mpram_nr1w #(.ABITS(10), .DBITS(32), .NRPORTS(2), .RDPIPE(0), .BYPASS(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
    .raddr_i(raddr), .re_i(re), .dout_o(dout0), .dvalid_o(dv0));

  peripheral_mpram_nr1w #(.ABITS(10), .DBITS(32), .NRPORTS(2), .RDPIPE(1), .BYPASS(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
    .raddr_i(raddr), .re_i(re), .dout_o(dout1), .dvalid_o(dv1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle();
    we = 1'b0;
    re = '0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1;
    waddr = a[9:0];
    din = d;
    be = b;
  endtask

  task automatic rd(input int p, input int a);
    re[p] = 1'b1;
    raddr[p*10 +: 10] = a[9:0];
  endtask

  task automatic tick();
    exp_t e;
    logic [31:0] w;
    int a;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        if (rst_ni && re[p]) begin
          a = int'(raddr[p*10 +: 10]);
          w = mdl[a];
          if (d == 0 && we && a == int'(waddr))
            for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = din[b*8 +: 8];
          e.data = w;
          e.due = cyc + 1 + d;
          sb[d*2+p].push_back(e);
        end
    if (rst_ni && we) begin
      w = mdl.exists(int'(waddr)) ? mdl[int'(waddr)] : 32'h0;
      for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = din[b*8 +: 8];
      mdl[int'(waddr)] = w;
    end
    @(posedge clk);
    cyc++;
    if (!rst_ni) for (int k = 0; k < 4; k++) sb[k].delete();
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic v;
    logic [31:0] got;
    if (mon_en)
      for (int k = 0; k < 4; k++) begin
        v = (k < 2) ? dv0[k] : dv1[k-2];
        got = (k < 2) ? dout0[k*32 +: 32] : dout1[(k-2)*32 +: 32];
        if (v) begin
          if (sb[k].size() == 0) check($sformatf("spurious_dvalid_%0d", k), 64'd1, 64'd0);
          else begin
            e = sb[k].pop_front();
            check($sformatf("rdata_%0d", k), {32'h0, got}, {32'h0, e.data});
            check($sformatf("latency_%0d", k), 64'(cyc), 64'(e.due));
          end
        end else if (sb[k].size() != 0 && sb[k][0].due <= cyc) begin
          void'(sb[k].pop_front());
          check($sformatf("missing_dvalid_%0d", k), 64'd0, 64'd1);
        end
      end
  end

  initial begin
    idle();
    wr(5, 32'h0000_5555, 4'hF);
    tick();
    rst_ni = 1'b0;
    wr(5, 32'hFFFF_FFFF, 4'hF);
    rd(0, 5);
    rd(1, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_dout0", dout0, 64'h0);
      check("rst_dv0", {62'h0, dv0}, 64'h0);
      check("rst_dout1", dout1, 64'h0);
      check("rst_dv1", {62'h0, dv1}, 64'h0);
    end
    rst_ni = 1'b1;
    idle();
    mon_en = 1'b1;
    rd(0, 5);
    rd(1, 5);
    tick();
    idle();
    tick();
    check("rst_keeps_array", {32'h0, dout1[31:0]}, 64'h0000_5555);
    tick();
    wr(16, 32'hDEAD_BEEF, 4'hF);
    tick();
    idle();
    rd(0, 16);
    rd(1, 16);
    tick();
    idle();
    tick();
    tick();
    wr(32, 32'h1122_3344, 4'hF);
    tick();
    wr(32, 32'hAABB_CCDD, 4'b0101);
    tick();
    idle();
    rd(0, 32);
    tick();
    idle();
    tick();
    check("partial_write", {32'h0, dout1[31:0]}, 64'h11BB_33DD);
    tick();
    wr(48, 32'h1122_3344, 4'hF);
    tick();
    wr(49, 32'h5566_7788, 4'hF);
    tick();
    wr(48, 32'hAABB_CCDD, 4'b0011);
    rd(0, 48);
    rd(1, 49);
    tick();
    idle();
    check("collision_bypass", {32'h0, dout0[31:0]}, 64'h1122_CCDD);
    check("collision_other_port", {32'h0, dout0[63:32]}, 64'h5566_7788);
    tick();
    check("collision_oldata", {32'h0, dout1[31:0]}, 64'h1122_3344);
    rd(0, 48);
    tick();
    idle();
    tick();
    tick();
    rd(0, 16);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_pipe", {32'h0, dout1[31:0]}, 64'hDEAD_BEEF);
      check("hold_nopipe", {32'h0, dout0[31:0]}, 64'hDEAD_BEEF);
    end
    rd(0, 16);
    rd(1, 16);
    tick();
    idle();
    rst_ni = 1'b0;
    tick();
    check("midrst_dout", dout1, 64'h0);
    check("midrst_dv", {62'h0, dv1}, 64'h0);
    rst_ni = 1'b1;
    tick();
    check("postrst_dout", dout1, 64'h0);
    check("postrst_dv", {62'h0, dv1}, 64'h0);
    for (int i = 0; i < 8; i++) begin
      wr(64 + i, $urandom, 4'hF);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      idle();
      wr(64 + ((i + 3) % 8), $urandom, 4'($urandom_range(0, 15)));
      rd(0, 64 + (i % 8));
      rd(1, 71 - (i % 8));
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) tick();
    for (int k = 0; k < 4; k++) check($sformatf("drain_%0d", k), 64'(sb[k].size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/peripheral_mpram_nr1w.md
# peripheral_mpram_nr1w

Generic multi-read-port, single-write-port RAM block for the MPSoC memory subsystem, sitting behind the AHB3 and other bus interface adapters. It serves NRPORTS independent synchronous read ports from one byte-maskable write port. Simultaneous read and write to the same address are resolved per byte lane, with bypass ("write-first") or old-data ("read-first") behaviour. An optional output pipeline stage and per-port data-valid strobes are provided.

## Interface
- ABITS, 10, address width; depth is 2**ABITS words
- DBITS, 32, data width; byte lanes BBITS=(DBITS+7)/8, top lane partial when DBITS%8≠0
- NRPORTS, 2, number of read ports, legal 1..8
- RDPIPE, 0, extra output register stages, legal 0 or 1
- BYPASS, 1, 1 = write-first per byte lane, 0 = read-first (old data)
- clk_i  input  1  single clock, all logic on rising edge
- rst_ni  input  1  reset, synchronous, active-low
- waddr_i  input  ABITS  write address
- din_i  input  DBITS  write data
- we_i  input  1  write enable
- be_i  input  BBITS  byte enables, bit b covers din_i[8b+7:8b] (clipped to DBITS)
- raddr_i  input  NRPORTS*ABITS  read addresses, port p at [p*ABITS +: ABITS]
- re_i  input  NRPORTS  read enables
- dout_o  output  NRPORTS*DBITS  read data, port p at [p*DBITS +: DBITS]
- dvalid_o  output  NRPORTS  high for one cycle when dout_o for port p carries newly read data

## Operation
- Storage is one copy of the array per read port, with the write port broadcast to all copies. Each copy stays inferable as a simple dual-port RAM. Contents of every copy are identical at all times.
- Write: on an edge with we_i=1 and rst_ni=1, each lane b with be_i[b]=1 gets din_i lane b. Lanes with be_i[b]=0 are unchanged. A write with be_i=0 is a no-op.
- Read: on an edge with re_i[p]=1, port p samples the array word at raddr_i[p].
- Collision (same edge, we_i=1, re_i[p]=1, raddr_i[p]==waddr_i):
  - BYPASS=1: returned lane b = din_i lane b if be_i[b], else the old array lane. This is a per-lane merge with no X propagation.
  - BYPASS=0: returned word = the array content before the write.
  - Each port resolves its collision independently.
- re_i[p]=0: the port's data path holds; dout_o[p] keeps its last value; dvalid_o[p]=0.
- RDPIPE=1: one register stage follows the read stage. It loads only when its input is valid, so dout_o holds between reads.
- Reads already issued do not see later writes. Data reflects the array (plus bypass) at the read edge only.
- Reset (rst_ni=0 at an edge):
  - dout_o=0, dvalid_o=0, all pipeline valid bits cleared.
  - Writes are suppressed.
  - Array contents are not cleared.
- Reset mid-operation discards in-flight reads; no dvalid_o is issued for them.
- Reads of never-written words return unknown data. Only dvalid_o is defined for them.

## Timing
- Read latency: a read sampled at edge N drives dout_o/dvalid_o after edge N+RDPIPE; dvalid_o is high during cycle N+RDPIPE+1.
- Back-to-back reads on every cycle give full throughput: one word per port per cycle.
- Write-to-read:
  - A read at the edge after a write sees the new data regardless of BYPASS.
  - A same-edge read follows the collision rule above.
- dvalid_o[p] is registered, aligned with dout_o[p], and never high while rst_ni was low at the preceding edge.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then idle (RDPIPE=0, NRPORTS=2): hold rst_ni=0 for 3 cycles with we_i=1 at addr 5.
  - dout_o=0 and dvalid_o=0 throughout.
  - After release, the first read of addr 5 returns the value it held before reset, not the value on din_i.
- Basic write/read: write 0xDEADBEEF to 0x010 with be=0xF; on the next cycle read 0x010 on both ports.
  - Both ports return 0xDEADBEEF one cycle later (two with RDPIPE=1), with a dvalid_o pulse.
- Partial write: start with 0x11223344 at 0x020; write din=0xAABBCCDD with be=0b0101.
  - A following read returns 0x11BB33DD.
- Collision: start with 0x11223344 at 0x030; write din=0xAABBCCDD with be=0b0011 while port 0 reads 0x030 and port 1 reads 0x031.
  - BYPASS=1: port 0 = 0x1122CCDD.
  - BYPASS=0: port 0 = 0x11223344.
  - In both modes port 1 returns its own word.
- Hold and pipeline (RDPIPE=1): read 0x010 once, then drop re_i for 4 cycles.
  - dvalid_o pulses once, 2 cycles after the read.
  - dout_o holds 0xDEADBEEF for all 4 cycles.
- Reset mid-read (RDPIPE=1): issue a read, then assert rst_ni=0 on the next edge.
  - No dvalid_o pulse appears.
  - dout_o=0 until the next completed read.
